// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with a free-running digit scanner.
// Outputs decode registered state only; wrap is a registered one-cycle pulse.
module bcd_scan_counter #(
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned SCAN_DIV = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic       clear,
    output logic [3:0] digit,
    output logic [3:0] digit_sel,
    output logic       blank,
    output logic       wrap
);

    logic [3:0]  r_cnt [4];
    logic [15:0] r_presc;
    logic [15:0] r_scan_tmr;
    logic [1:0]  r_idx;
    logic        r_wrap;

    logic        w_tick;
    logic        w_scan_adv;
    logic        w_wraps;
    logic        w_blank;
    logic [3:0]  w_cnt_nxt [4];

    assign w_tick     = en && !clear && (r_presc == 16'(PRESCALE - 1));
    assign w_scan_adv = (r_scan_tmr == 16'(SCAN_DIV - 1));

    // Ripple a decimal carry/borrow upward; a carry out of the top digit means wrap.
    always_comb begin
        logic w_carry;
        w_carry = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_carry) begin
                if (up) begin
                    if (r_cnt[i] == 4'd9) begin
                        w_cnt_nxt[i] = 4'd0;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + 4'd1;
                        w_carry      = 1'b0;
                    end
                end else begin
                    if (r_cnt[i] == 4'd0) begin
                        w_cnt_nxt[i] = 4'd9;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] - 4'd1;
                        w_carry      = 1'b0;
                    end
                end
            end
        end
        w_wraps = w_carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) r_cnt[i] <= '0;
            r_presc <= '0;
            r_wrap  <= 1'b0;
        end else if (clear) begin
            for (int unsigned i = 0; i < 4; i++) r_cnt[i] <= '0;
            r_presc <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= w_tick && w_wraps;
            if (en) begin
                r_presc <= w_tick ? '0 : r_presc + 16'd1;
            end
            if (w_tick) begin
                for (int unsigned i = 0; i < 4; i++) r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_tmr <= '0;
            r_idx      <= '0;
        end else if (w_scan_adv) begin
            r_scan_tmr <= '0;
            r_idx      <= r_idx + 2'd1;
        end else begin
            r_scan_tmr <= r_scan_tmr + 16'd1;
        end
    end

    // Blank when the selected digit and every digit above it are zero, except index 0.
    always_comb begin
        w_blank = (r_idx != 2'd0);
        for (int unsigned i = 0; i < 4; i++) begin
            if (i >= 32'(r_idx) && r_cnt[i] != 4'd0) w_blank = 1'b0;
        end
    end

    assign digit     = r_cnt[r_idx];
    assign digit_sel = 4'b0001 << r_idx;
    assign blank     = w_blank;
    assign wrap      = r_wrap;

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Four-digit BCD up/down counter with a built-in display scanner.
- Presents one digit at a time as a 4-bit BCD code plus a one-hot digit select.
- Sits directly upstream of the team's 7-segment digit decoder; its digit output feeds the decoder input, and digit_sel drives the display common pins.
- Outputs are driven only from registered state; no combinational path from any input to any output.

Parameters:
- PRESCALE, 1000: clk cycles per count tick; legal range 1..65535.
- SCAN_DIV, 250: clk cycles each digit stays selected before the scanner advances; legal range 1..65535.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset; deassertion synchronous to clk upstream.
- en  input  1  count enable; when low, prescaler and count hold; scanning continues.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled on the tick cycle.
- clear  input  1  synchronous clear of count and prescaler.
- digit  output  4  BCD value of the currently selected digit, always 0..9.
- digit_sel  output  4  one-hot select; bit 0 = least-significant digit.
- blank  output  1  1 = currently selected digit is a suppressed leading zero.
- wrap  output  1  one-cycle pulse on the cycle after a tick that wraps the count.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - count = 0000; prescaler = 0; scan timer = 0; scan index = 0.
  - Outputs: digit=0, digit_sel=4'b0001, blank=0, wrap=0.
- Prescaler:
  - While en=1 and clear=0, counts 0..PRESCALE-1.
  - tick is asserted on the cycle the prescaler equals PRESCALE-1, then it returns to 0.
  - PRESCALE=1 gives a tick on every enabled cycle.
  - While en=0, the prescaler holds its value and does not reset.
- Count update on tick:
  - up=1: BCD increment with decimal carry; a digit 9 becomes 0 and carries into the next digit.
  - up=0: BCD decrement with decimal borrow; a digit 0 becomes 9 and borrows from the next digit.
  - Wrap-around: 9999 -> 0000 on increment and 0000 -> 9999 on decrement. Either sets wrap=1 for exactly the next cycle; otherwise wrap=0.
  - Digits never hold values 10..15.
- clear=1:
  - Next edge: count=0000 and prescaler=0.
  - Overrides en and any tick that cycle; no wrap pulse.
  - Does not affect the scan timer or scan index.
- Scanner:
  - Free-running, independent of en.
  - Scan timer counts 0..SCAN_DIV-1. On the cycle it equals SCAN_DIV-1 it returns to 0 and the index advances 0->1->2->3->0.
- Output mapping (functions of current registered state):
  - digit = count digit[index].
  - digit_sel = 1 << index.
  - A count update is visible on digit the cycle after the tick edge.
- Leading-zero blanking:
  - blank=1 iff index != 0, digit[index]=0, and all digits above index are 0.
  - Index 0 is never blanked, so 0000 shows a single "0".
  - blank is advisory; digit still carries 0 when blank=1.
- Simultaneous events:
  - Tick on the same cycle as a scan advance: both take effect on that edge, and the new index shows the new count.
  - clear together with a tick: clear wins.
  - Changing up between ticks has no effect until the next tick.
- Mid-operation reset: all state returns to reset values immediately. The first tick after release occurs PRESCALE enabled cycles later.

Test Plan:
- Reset check (PRESCALE=4, SCAN_DIV=2): assert rst_n=0 mid-count -> outputs immediately digit=0, digit_sel=0001, blank=0, wrap=0. After release, first tick 4 cycles later gives count 0001.
- Increment carry: count 0099, up=1, one tick -> count 0100. Scan shows digits 0,0,1,blank-0 on sel 0001,0010,0100,1000, with blank=0,0,0,1 respectively.
- Wrap both directions:
  - 9999, up=1, tick -> 0000 and wrap high for exactly 1 cycle.
  - 0000, up=0, tick -> 9999 and wrap pulses once.
- Enable and clear priority:
  - en=0 for 20 cycles -> count and prescaler frozen, digit_sel still rotating every 2 cycles.
  - clear=1 coincident with tick at 0042 -> 0000, no wrap.
- Blanking: count 0007 -> blank=0 on sel 0001, blank=1 on sels 0010, 0100, 1000. Count 0000 -> blank only on the upper three digits.
- Tick/scan coincidence (PRESCALE=SCAN_DIV=3): verify the new index shows the post-tick count on the same edge, and that digit never exceeds 9 over 10000 random up/down ticks compared against a reference model.
